// File: rtl/branch_predictor_bht_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_bht_if #(
    parameter int IDX_BITS = 6
);
    logic [63:0]         if_pc;
    logic [31:0]         if_instr;
    logic [63:0]         pred_pc;
    logic                pred_taken;
    logic [IDX_BITS-1:0] pred_idx;
    logic                ex_valid;
    logic                ex_is_cond;
    logic                ex_taken;
    logic [IDX_BITS-1:0] ex_idx;
    logic [63:0]         ex_pred_pc;
    logic [63:0]         ex_actual_pc;
    logic                flush;
    logic [31:0]         branch_count;
    logic [31:0]         mispredict_count;

    modport master (
        output if_pc, if_instr,
        output ex_valid, ex_is_cond, ex_taken,
        output ex_idx, ex_pred_pc, ex_actual_pc,
        input  pred_pc, pred_taken, pred_idx,
        input  flush, branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, if_instr,
        input  ex_valid, ex_is_cond, ex_taken,
        input  ex_idx, ex_pred_pc, ex_actual_pc,
        output pred_pc, pred_taken, pred_idx,
        output flush, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Bimodal / gshare branch history table with saturating counters.
// Ports: clk, rst (async active-low), bus (fetch lookup + EX resolve).
module branch_predictor_bht #(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 0
) (
    input logic                  clk,
    input logic                  rst,
    branch_predictor_bht_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT =
        CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [CTR_BITS-1:0] pht [ENTRIES];
    logic [GW-1:0]       ghr;
    logic [IDX_BITS-1:0] hist;
    logic [IDX_BITS-1:0] pc_idx;
    logic [IDX_BITS-1:0] idx;
    logic [31:0]         ins;
    logic [63:0]         b_imm;
    logic [63:0]         j_imm;
    logic                is_branch;
    logic                is_jal;
    logic                taken;
    logic [63:0]         target;
    logic                flush;
    logic                cond_upd;
    logic [31:0]         br_cnt;
    logic [31:0]         mp_cnt;

    assign ins = bus.if_instr;

    assign b_imm = {{51{ins[31]}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};
    assign j_imm = {{43{ins[31]}}, ins[31], ins[19:12],
                    ins[20], ins[30:21], 1'b0};

    // In bimodal mode ghr is held at zero, so hist is zero too.
    assign hist   = IDX_BITS'(ghr);
    assign pc_idx = bus.if_pc[IDX_BITS+1:2];
    assign idx    = pc_idx ^ hist;

    always_comb begin
        is_branch = 1'b0;
        is_jal    = 1'b0;
        unique case (ins[6:0])
            OP_BRANCH: is_branch = 1'b1;
            OP_JAL:    is_jal    = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = bus.if_pc + 64'd4;
        if (is_branch) begin
            taken = pht[idx][CTR_BITS-1];
            if (taken) target = bus.if_pc + b_imm;
        end else if (is_jal) begin
            taken  = 1'b1;
            target = bus.if_pc + j_imm;
        end
    end

    assign flush = bus.ex_valid &&
                   (bus.ex_pred_pc != bus.ex_actual_pc);
    assign cond_upd = bus.ex_valid & bus.ex_is_cond;

    assign bus.pred_taken       = taken;
    assign bus.pred_idx         = idx;
    assign bus.pred_pc          = flush ? bus.ex_actual_pc : target;
    assign bus.flush            = flush;
    assign bus.branch_count     = br_cnt;
    assign bus.mispredict_count = mp_cnt;

    // Table read is combinational from the register state, so a
    // same-cycle update at the lookup index is seen one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= CTR_INIT;
        end else if (cond_upd) begin
            if (bus.ex_taken) begin
                if (pht[bus.ex_idx] != CTR_MAX)
                    pht[bus.ex_idx] <= pht[bus.ex_idx] + 1'b1;
            end else begin
                if (pht[bus.ex_idx] != '0)
                    pht[bus.ex_idx] <= pht[bus.ex_idx] - 1'b1;
            end
        end
    end

    generate
        if (GHR_BITS > 0) begin : g_gshare
            // Non-speculative: history advances only at resolution.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) ghr <= '0;
                else if (cond_upd) ghr <= GW'({ghr, bus.ex_taken});
            end
        end else begin : g_bimodal
            assign ghr = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (cond_upd && br_cnt != '1) br_cnt <= br_cnt + 32'd1;
            if (flush && mp_cnt != '1)    mp_cnt <= mp_cnt + 32'd1;
        end
    end
endmodule
